systolic_pe_os: RTL and testbench
=================================

# systolic_pe_os

Parametrised output-stationary processing element for the 2D systolic matrix-multiply array. Operands flow in from the top and left and are forwarded bottom/right with one cycle of latency. The block keeps a local saturating accumulator and a tile state machine, and supports signed or unsigned operands. At the end of each tile it captures the result into an output buffer that shifts down a per-column result chain to the array edge.

## Interface
- DATA_W, 4: operand width in bits.
- ACC_W, 11: accumulator and result width; must be ≥ 2*DATA_W.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- top_i  in  DATA_W  operand from the PE above.
- top_valid_i  in  1  top_i is valid.
- left_i  in  DATA_W  operand from the PE to the left.
- left_valid_i  in  1  left_i is valid.
- last_i  in  1  the current operand pair is the last of the tile.
- signed_i  in  1  1 = two's-complement operands and accumulator; 0 = unsigned.
- clear_i  in  1  soft clear of the accumulator, FSM and flags.
- bottom_o / bottom_valid_o  out  DATA_W / 1  registered copy of top_i / top_valid_i.
- right_o / right_valid_o  out  DATA_W / 1  registered copy of left_i / left_valid_i.
- shift_i  in  1  advance the result chain.
- res_i / res_valid_i  in  ACC_W / 1  result chain input from the upstream PE.
- res_o / res_valid_o  out  ACC_W / 1  output result buffer.
- ovf_o  out  1  sticky saturation flag.
- err_o  out  1  sticky protocol-error flag.

## Operation
- Forwarding:
  - Every cycle, bottom_o/right_o and their valids load top_i/left_i and their valids, independent of the FSM.
- fire = top_valid_i & left_valid_i.
  - If exactly one valid is high: no MAC occurs and err_o is set.
- Product = top_i*left_i, full 2*DATA_W bits.
  - Sign-extended to ACC_W when signed_i=1; zero-extended otherwise.
- Sum = acc + product, computed at ACC_W+1 bits, then saturated:
  - unsigned: clamp to 2^ACC_W−1;
  - signed: clamp to the range [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any clamp sets ovf_o.
- signed_i is held constant within a tile; if it changes mid-tile, the result is undefined.
- FSM states:
  - IDLE: acc=0. On fire with last_i=0: acc←product, go to ACC. On fire with last_i=1: capture product, stay in IDLE.
  - ACC: on fire, acc←saturated sum. If last_i=1, capture the sum, acc←0, go to IDLE.
- Capture: res_o←final sum, res_valid_o←1.
- Result chain:
  - When shift_i=1 and there is no capture: res_o←res_i, res_valid_o←res_valid_i.
  - shift_i with no valid upstream data shifts in res_valid=0.
- Simultaneous capture and shift_i:
  - Capture wins; the old value has already left downstream.
  - If res_valid_i=1 in that cycle, the upstream value is lost and err_o is set.
- Overrun: a capture while res_valid_o=1 and shift_i=0 overwrites the buffer and sets err_o.
- clear_i:
  - Forces acc=0, state IDLE, and clears ovf_o and err_o.
  - A fire in the same cycle is discarded.
  - Forwarding registers and the result chain are unaffected.
- rst_i clears everything, including the forwarding registers and the result chain; it takes priority over all other inputs.

## Timing
- Reset values: bottom_o=0, right_o=0, all valids=0, res_o=0, ovf_o=0, err_o=0, acc=0, state IDLE.
- Forwarding latency: 1 cycle.
- MAC: one operand pair per cycle, no bubbles needed; the accumulator updates on the edge that samples fire.
- Result latency: res_valid_o rises 1 cycle after the fire carrying last_i.
- Back-to-back tiles: a fire in the cycle after last starts the new tile from IDLE with no dead cycle.
- Chain: one PE hop per cycle while shift_i=1. An N-row column drains in N cycles.
- Flag timing: ovf_o and err_o assert 1 cycle after the causing edge's inputs and remain high until clear_i or rst_i.
- Reset mid-tile: the partial sum is lost; next cycle shows the reset values.

## Test plan
- Forwarding: top_i=5, left_i=3, both valids high for one cycle → next cycle bottom_o=5, right_o=3, both valids=1; the cycle after, both valids=0.
- Unsigned tile (DATA_W=4, ACC_W=11): fire pairs (3,4), (5,6), (15,15) with last on the third → res_o=267 and res_valid_o=1 one cycle later; ovf_o=0; an immediate new pair (2,2) with last gives res_o=4.
- Saturation: ACC_W=8 unsigned, (15,15)×2 with last → res_o=255, ovf_o=1. Signed (ACC_W=8): (−8,7)×3 → res_o=−128 (0x80), ovf_o=1; clear_i → ovf_o=0.
- Protocol errors: top_valid_i alone → acc unchanged, err_o=1. Capture while res_valid_o=1 with shift_i=0 → new value present, err_o=1.
- Chain: 3 PEs in a column capture 10, 20, 30; shift_i held for 3 cycles → the bottom PE's res_o shows 30, 20, 10 in order, then res_valid_o=0.
- Reset mid-tile: fire (7,7) twice without last, assert rst_i → all outputs at reset values; a following (1,1) with last → res_o=1.

Source files
------------

// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: forwards operands right/down, accumulates a
// saturating MAC per tile, and pushes tile results down a per-column chain.
module systolic_pe_os #(
   parameter int DATA_W = 4,
   parameter int ACC_W  = 11
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] top_i,
   input  logic              top_valid_i,
   input  logic [DATA_W-1:0] left_i,
   input  logic              left_valid_i,
   input  logic              last_i,
   input  logic              signed_i,
   input  logic              clear_i,
   output logic [DATA_W-1:0] bottom_o,
   output logic              bottom_valid_o,
   output logic [DATA_W-1:0] right_o,
   output logic              right_valid_o,
   input  logic              shift_i,
   input  logic [ACC_W-1:0]  res_i,
   input  logic              res_valid_i,
   output logic [ACC_W-1:0]  res_o,
   output logic              res_valid_o,
   output logic              ovf_o,
   output logic              err_o
);

   // state | meaning
   // IDLE  | no tile in progress, acc holds 0
   // ACC   | tile in progress, acc holds the running sum
   typedef enum logic {IDLE, ACC} state_t;

   state_t             state, state_nx;
   logic [ACC_W-1:0]   acc, acc_nx;
   logic               fire, mismatch, capture;
   logic [2*DATA_W-1:0] top_x, left_x, prod;
   logic [ACC_W:0]     acc_x, prod_x, sum;
   logic               clamp;
   logic [ACC_W-1:0]   sat;
   logic               ovf_set, err_set;

   assign fire     = top_valid_i & left_valid_i;
   assign mismatch = top_valid_i ^ left_valid_i;

   // One multiplier serves both modes: operands are pre-extended to the product
   // width, so the low 2*DATA_W bits are the correct signed or unsigned product.
   assign top_x  = {{DATA_W{signed_i & top_i[DATA_W-1]}}, top_i};
   assign left_x = {{DATA_W{signed_i & left_i[DATA_W-1]}}, left_i};
   assign prod   = top_x * left_x;

   assign prod_x = {{(ACC_W+1-2*DATA_W){signed_i & prod[2*DATA_W-1]}}, prod};
   assign acc_x  = {signed_i & acc[ACC_W-1], acc};
   assign sum    = acc_x + prod_x;

   always_comb begin
      clamp = 1'b0;
      sat   = sum[ACC_W-1:0];
      if (signed_i) begin
         if (sum[ACC_W] != sum[ACC_W-1]) begin
            clamp = 1'b1;
            sat   = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end
      end else if (sum[ACC_W]) begin
         clamp = 1'b1;
         sat   = {ACC_W{1'b1}};
      end
   end

   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      capture  = 1'b0;
      if (clear_i) begin
         state_nx = IDLE;
         acc_nx   = '0;
      end else if (fire) begin
         if (last_i) begin
            capture  = 1'b1;
            acc_nx   = '0;
            state_nx = IDLE;
         end else begin
            acc_nx   = sat;
            state_nx = ACC;
         end
      end
   end

   assign ovf_set = fire & ~clear_i & clamp;
   assign err_set = mismatch
                  | (capture & shift_i & res_valid_i)
                  | (capture & res_valid_o & ~shift_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         acc            <= '0;
         bottom_o       <= '0;
         bottom_valid_o <= 1'b0;
         right_o        <= '0;
         right_valid_o  <= 1'b0;
         res_o          <= '0;
         res_valid_o    <= 1'b0;
         ovf_o          <= 1'b0;
         err_o          <= 1'b0;
      end else begin
         state          <= state_nx;
         acc            <= acc_nx;
         bottom_o       <= top_i;
         bottom_valid_o <= top_valid_i;
         right_o        <= left_i;
         right_valid_o  <= left_valid_i;
         // A capture takes the slot even when shifting; the old value moves on downstream.
         if (capture) begin
            res_o       <= sat;
            res_valid_o <= 1'b1;
         end else if (shift_i) begin
            res_o       <= res_i;
            res_valid_o <= res_valid_i;
         end
         ovf_o <= clear_i ? 1'b0 : (ovf_o | ovf_set);
         err_o <= clear_i ? 1'b0 : (err_o | err_set);
      end
   end

endmodule

// File: tb/tb_systolic_pe_os.sv
// Directed bench for systolic_pe_os: vector table on an 11-bit PE, an 8-bit PE
// for saturation, and a three-PE column for the result chain.
module tb_systolic_pe_os;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // main PE, ACC_W=11
   logic        m_rst, m_tv, m_lv, m_last, m_sgn, m_clr, m_shift, m_rvi;
   logic [3:0]  m_top, m_left;
   logic [10:0] m_ri;
   logic [3:0]  m_bot, m_right;
   logic        m_bv, m_rtv, m_rv, m_ovf, m_err;
   logic [10:0] m_res;

   systolic_pe_os #(.DATA_W(4), .ACC_W(11)) u_main (
      .clk_i(clk_i), .rst_i(m_rst), .top_i(m_top), .top_valid_i(m_tv),
      .left_i(m_left), .left_valid_i(m_lv), .last_i(m_last), .signed_i(m_sgn),
      .clear_i(m_clr), .bottom_o(m_bot), .bottom_valid_o(m_bv), .right_o(m_right),
      .right_valid_o(m_rtv), .shift_i(m_shift), .res_i(m_ri), .res_valid_i(m_rvi),
      .res_o(m_res), .res_valid_o(m_rv), .ovf_o(m_ovf), .err_o(m_err));

   // saturation PE, ACC_W=8
   logic        rst;
   logic        s_tv, s_lv, s_last, s_sgn, s_clr, s_shift;
   logic [3:0]  s_top, s_left;
   logic [3:0]  s_bot, s_right;
   logic        s_bv, s_rtv, s_rv, s_ovf, s_err;
   logic [7:0]  s_res;

   systolic_pe_os #(.DATA_W(4), .ACC_W(8)) u_sat (
      .clk_i(clk_i), .rst_i(rst), .top_i(s_top), .top_valid_i(s_tv),
      .left_i(s_left), .left_valid_i(s_lv), .last_i(s_last), .signed_i(s_sgn),
      .clear_i(s_clr), .bottom_o(s_bot), .bottom_valid_o(s_bv), .right_o(s_right),
      .right_valid_o(s_rtv), .shift_i(s_shift), .res_i(8'd0), .res_valid_i(1'b0),
      .res_o(s_res), .res_valid_o(s_rv), .ovf_o(s_ovf), .err_o(s_err));

   // three-PE column: c[0] is the top, c[2] the bottom edge
   logic        c_fire, c_last, c_shift;
   logic [3:0]  c_top [3];
   logic [3:0]  c_left [3];
   logic [3:0]  c_bot [3];
   logic [3:0]  c_right [3];
   logic        c_bv [3];
   logic        c_rtv [3];
   logic        c_ovf [3];
   logic        c_err [3];
   logic [10:0] c_res [3];
   logic        c_rv [3];

   systolic_pe_os #(.DATA_W(4), .ACC_W(11)) u_c0 (
      .clk_i(clk_i), .rst_i(rst), .top_i(c_top[0]), .top_valid_i(c_fire),
      .left_i(c_left[0]), .left_valid_i(c_fire), .last_i(c_last), .signed_i(1'b0),
      .clear_i(1'b0), .bottom_o(c_bot[0]), .bottom_valid_o(c_bv[0]), .right_o(c_right[0]),
      .right_valid_o(c_rtv[0]), .shift_i(c_shift), .res_i(11'd0), .res_valid_i(1'b0),
      .res_o(c_res[0]), .res_valid_o(c_rv[0]), .ovf_o(c_ovf[0]), .err_o(c_err[0]));
   systolic_pe_os #(.DATA_W(4), .ACC_W(11)) u_c1 (
      .clk_i(clk_i), .rst_i(rst), .top_i(c_top[1]), .top_valid_i(c_fire),
      .left_i(c_left[1]), .left_valid_i(c_fire), .last_i(c_last), .signed_i(1'b0),
      .clear_i(1'b0), .bottom_o(c_bot[1]), .bottom_valid_o(c_bv[1]), .right_o(c_right[1]),
      .right_valid_o(c_rtv[1]), .shift_i(c_shift), .res_i(c_res[0]), .res_valid_i(c_rv[0]),
      .res_o(c_res[1]), .res_valid_o(c_rv[1]), .ovf_o(c_ovf[1]), .err_o(c_err[1]));
   systolic_pe_os #(.DATA_W(4), .ACC_W(11)) u_c2 (
      .clk_i(clk_i), .rst_i(rst), .top_i(c_top[2]), .top_valid_i(c_fire),
      .left_i(c_left[2]), .left_valid_i(c_fire), .last_i(c_last), .signed_i(1'b0),
      .clear_i(1'b0), .bottom_o(c_bot[2]), .bottom_valid_o(c_bv[2]), .right_o(c_right[2]),
      .right_valid_o(c_rtv[2]), .shift_i(c_shift), .res_i(c_res[1]), .res_valid_i(c_rv[1]),
      .res_o(c_res[2]), .res_valid_o(c_rv[2]), .ovf_o(c_ovf[2]), .err_o(c_err[2]));

   typedef struct {
      logic [3:0]  top;   logic tv;  logic [3:0] left; logic lv;
      logic        last;  logic sgn; logic clr;        logic shift;
      logic [10:0] ri;    logic rvi;
      logic [10:0] e_res; logic e_rv; logic e_ovf; logic e_err;
      logic [3:0]  e_bot; logic e_bv; logic [3:0] e_right; logic e_rtv;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic drive_main(input vec_t v);
      m_top = v.top; m_tv = v.tv; m_left = v.left; m_lv = v.lv;
      m_last = v.last; m_sgn = v.sgn; m_clr = v.clr; m_shift = v.shift;
      m_ri = v.ri; m_rvi = v.rvi;
   endtask

   task automatic main_pair(input logic [3:0] t, input logic tv, input logic [3:0] l,
                            input logic lv, input logic last);
      m_top = t; m_tv = tv; m_left = l; m_lv = lv; m_last = last;
      m_sgn = 1'b0; m_clr = 1'b0; m_shift = 1'b0; m_ri = '0; m_rvi = 1'b0;
   endtask

   task automatic sat_pair(input logic [3:0] t, input logic [3:0] l, input logic v,
                           input logic last, input logic sgn, input logic clr, input logic sh);
      s_top = t; s_left = l; s_tv = v; s_lv = v; s_last = last;
      s_sgn = sgn; s_clr = clr; s_shift = sh;
   endtask

   initial begin
      //          top   tv    left  lv    last  sgn   clr   sh    ri       rvi   | res       rv    ovf   err   bot   bv    right rtv
      vecs[0]  = '{4'd5, 1'b1,4'd3, 1'b1,1'b1, 1'b0,1'b0, 1'b0,11'd0,  1'b0, 11'd15,  1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 4'd3, 1'b1};
      vecs[1]  = '{4'd0, 1'b0,4'd0, 1'b0,1'b0, 1'b0,1'b0, 1'b1,11'd0,  1'b0, 11'd0,   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
      vecs[2]  = '{4'd3, 1'b1,4'd4, 1'b1,1'b0, 1'b0,1'b0, 1'b0,11'd0,  1'b0, 11'd0,   1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd4, 1'b1};
      vecs[3]  = '{4'd5, 1'b1,4'd6, 1'b1,1'b0, 1'b0,1'b0, 1'b0,11'd0,  1'b0, 11'd0,   1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1};
      vecs[4]  = '{4'd15,1'b1,4'd15,1'b1,1'b1, 1'b0,1'b0, 1'b0,11'd0,  1'b0, 11'd267, 1'b1, 1'b0, 1'b0, 4'd15,1'b1, 4'd15,1'b1};
      vecs[5]  = '{4'd2, 1'b1,4'd2, 1'b1,1'b1, 1'b0,1'b0, 1'b1,11'd0,  1'b0, 11'd4,   1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 4'd2, 1'b1};
      vecs[6]  = '{4'd3, 1'b1,4'd3, 1'b1,1'b0, 1'b0,1'b0, 1'b1,11'd0,  1'b0, 11'd0,   1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1};
      vecs[7]  = '{4'd7, 1'b1,4'd0, 1'b0,1'b0, 1'b0,1'b0, 1'b0,11'd0,  1'b0, 11'd0,   1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0};
      vecs[8]  = '{4'd1, 1'b1,4'd2, 1'b1,1'b1, 1'b0,1'b0, 1'b0,11'd0,  1'b0, 11'd11,  1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1};
      vecs[9]  = '{4'd0, 1'b0,4'd0, 1'b0,1'b0, 1'b0,1'b1, 1'b0,11'd0,  1'b0, 11'd11,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
      vecs[10] = '{4'd2, 1'b1,4'd3, 1'b1,1'b1, 1'b0,1'b0, 1'b0,11'd0,  1'b0, 11'd6,   1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1};
      vecs[11] = '{4'd0, 1'b0,4'd0, 1'b0,1'b0, 1'b0,1'b1, 1'b0,11'd0,  1'b0, 11'd6,   1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
      vecs[12] = '{4'd4, 1'b1,4'd4, 1'b1,1'b1, 1'b0,1'b1, 1'b0,11'd0,  1'b0, 11'd6,   1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 4'd4, 1'b1};
      vecs[13] = '{4'd0, 1'b0,4'd0, 1'b0,1'b0, 1'b0,1'b0, 1'b1,11'd99, 1'b1, 11'd99,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
      vecs[14] = '{4'd1, 1'b1,4'd5, 1'b1,1'b1, 1'b0,1'b0, 1'b1,11'd77, 1'b1, 11'd5,   1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 4'd5, 1'b1};
      vecs[15] = '{4'd0, 1'b0,4'd0, 1'b0,1'b0, 1'b0,1'b1, 1'b0,11'd0,  1'b0, 11'd5,   1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
      // signed: (-3*5) + (2*-4) = -23
      vecs[16] = '{4'hD, 1'b1,4'd5, 1'b1,1'b0, 1'b1,1'b0, 1'b1,11'd0,  1'b0, 11'd0,   1'b0, 1'b0, 1'b0, 4'hD, 1'b1, 4'd5, 1'b1};
      vecs[17] = '{4'd2, 1'b1,4'hC, 1'b1,1'b1, 1'b1,1'b0, 1'b0,11'd0,  1'b0, 11'h7E9, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 4'hC, 1'b1};

      m_rst = 1'b1; rst = 1'b1;
      main_pair(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      sat_pair(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      c_fire = 1'b0; c_last = 1'b0; c_shift = 1'b0;
      for (int i = 0; i < 3; i++) begin c_top[i] = '0; c_left[i] = '0; end
      step(); step();

      chk("reset res", 32'(m_res), 32'd0);
      chk("reset valids", 32'({m_rv, m_bv, m_rtv}), 32'd0);
      chk("reset fwd", 32'({m_bot, m_right}), 32'd0);
      chk("reset flags", 32'({m_ovf, m_err}), 32'd0);
      m_rst = 1'b0; rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive_main(vecs[i]);
         step();
         chk($sformatf("row%0d res", i), 32'({m_rv, m_res}), 32'({vecs[i].e_rv, vecs[i].e_res}));
         chk($sformatf("row%0d flags", i), 32'({m_ovf, m_err}), 32'({vecs[i].e_ovf, vecs[i].e_err}));
         chk($sformatf("row%0d fwd", i), 32'({m_bv, m_bot, m_rtv, m_right}),
             32'({vecs[i].e_bv, vecs[i].e_bot, vecs[i].e_rtv, vecs[i].e_right}));
      end

      // reset mid-tile, with an error pending and a fire on the reset cycle
      main_pair(4'd7, 1'b1, 4'd7, 1'b1, 1'b0); step();
      main_pair(4'd7, 1'b1, 4'd7, 1'b1, 1'b0); step();
      main_pair(4'd7, 1'b1, 4'd0, 1'b0, 1'b0); step();
      chk("pre-reset err", 32'(m_err), 32'd1);
      main_pair(4'd7, 1'b1, 4'd7, 1'b1, 1'b1); m_rst = 1'b1; step();
      m_rst = 1'b0;
      chk("midreset res", 32'({m_rv, m_res}), 32'd0);
      chk("midreset fwd", 32'({m_bv, m_bot, m_rtv, m_right}), 32'd0);
      chk("midreset flags", 32'({m_ovf, m_err}), 32'd0);
      main_pair(4'd1, 1'b1, 4'd1, 1'b1, 1'b1); step();
      chk("after reset res", 32'({m_rv, m_res}), 32'({1'b1, 11'd1}));

      // unsigned saturation at ACC_W=8
      sat_pair(4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
      chk("sat ovf early", 32'(s_ovf), 32'd0);
      sat_pair(4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
      chk("usat res", 32'({s_rv, s_res}), 32'({1'b1, 8'd255}));
      chk("usat ovf", 32'(s_ovf), 32'd1);
      sat_pair(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step();
      chk("usat clear", 32'(s_ovf), 32'd0);
      // signed: three times -8*7 = -168 clamps to -128
      sat_pair(4'h8, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
      sat_pair(4'h8, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
      chk("ssat no ovf yet", 32'(s_ovf), 32'd0);
      sat_pair(4'h8, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); step();
      chk("ssat res", 32'({s_rv, s_res}), 32'({1'b1, 8'h80}));
      chk("ssat ovf", 32'(s_ovf), 32'd1);
      chk("ssat err", 32'(s_err), 32'd0);
      sat_pair(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step();
      chk("ssat clear", 32'(s_ovf), 32'd0);

      // column drain: capture 10, 20, 30 top to bottom, then shift three times
      c_top[0] = 4'd2; c_left[0] = 4'd5;
      c_top[1] = 4'd4; c_left[1] = 4'd5;
      c_top[2] = 4'd5; c_left[2] = 4'd6;
      c_fire = 1'b1; c_last = 1'b1; step();
      c_fire = 1'b0; c_last = 1'b0;
      chk("chain cap bottom", 32'({c_rv[2], c_res[2]}), 32'({1'b1, 11'd30}));
      chk("chain cap mid", 32'({c_rv[1], c_res[1]}), 32'({1'b1, 11'd20}));
      c_shift = 1'b1; step();
      chk("chain hop1", 32'({c_rv[2], c_res[2]}), 32'({1'b1, 11'd20}));
      step();
      chk("chain hop2", 32'({c_rv[2], c_res[2]}), 32'({1'b1, 11'd10}));
      step();
      chk("chain drained", 32'(c_rv[2]), 32'd0);
      c_shift = 1'b0;
      chk("chain err", 32'({c_err[0], c_err[1], c_err[2]}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
